// File: rtl/io_pkg.sv
// Shared definitions for the I/O bridge: I/O page base, register offsets and debounce FSM states.
package io_pkg;

   localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;

   localparam logic [9:0] LED_OFS = 10'h060;
   localparam logic [9:0] SW_OFS  = 10'h070;
   localparam logic [9:0] SEG_OFS = 10'h080;

   localparam int SW_W = 24;

   typedef enum logic {
      DB_STABLE   = 1'b0,
      DB_COUNTING = 1'b1
   } db_state_e;

   // True when more than one strobe is set (clearing the lowest set bit leaves something).
   function automatic logic multi_strobe(input logic [3:0] s);
      return (s & (s - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchronizer followed by a STABLE/COUNTING debounce FSM that
// accepts a new value only after DEBOUNCE_CYCLES consecutive identical samples.
module sw_debounce #(
   parameter int WIDTH           = 24,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] stable_o,
   output logic             changed_o
);
   import io_pkg::*;

   // One spare bit of headroom so the terminal count is always representable.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   db_state_e        state_q, state_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             changed_q, changed_d;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q    <= '0;
         sync_q    <= '0;
         state_q   <= DB_STABLE;
         stable_q  <= '0;
         cand_q    <= '0;
         cnt_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         meta_q    <= raw_i;
         sync_q    <= meta_q;
         state_q   <= state_d;
         stable_q  <= stable_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         changed_q <= changed_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      stable_d  = stable_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      changed_d = 1'b0;
      unique case (state_q)
         DB_STABLE: begin
            if (sync_q != stable_q) begin
               cand_d  = sync_q;
               cnt_d   = '0;
               state_d = DB_COUNTING;
            end
         end
         DB_COUNTING: begin
            // Returning to the old value must win: the candidate never equals the stable value.
            if (sync_q == stable_q) begin
               state_d = DB_STABLE;
            end else if (sync_q != cand_q) begin
               cand_d = sync_q;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               stable_d  = cand_q;
               changed_d = 1'b1;
               state_d   = DB_STABLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = DB_STABLE;
      endcase
   end

   assign stable_o  = stable_q;
   assign changed_o = changed_q;

endmodule

// File: rtl/io_bridge.sv
// Memory/I-O bridge: write-back mux, LED and seven-segment registers, debounced switches, sticky error.
// Build option: define IO_BRIDGE_SEG_EN to include the seven-segment register at offset 0x080.
module io_bridge #(
   parameter int          DEBOUNCE_CYCLES = 20000,
   parameter logic [31:0] IO_BASE         = io_pkg::IO_BASE
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mRead,
   input  logic        mWrite,
   input  logic        ioRead,
   input  logic        ioWrite,
   input  logic [31:0] addr_in,
   input  logic [31:0] m_rdata,
   input  logic [31:0] r_rdata,
   input  logic [23:0] switch_in,
   output logic [31:0] r_wdata,
   output logic [31:0] write_data,
   output logic [23:0] led_out,
   output logic [31:0] seg_out,
   output logic        sw_changed,
   output logic        io_err
);
   import io_pkg::*;

   logic [9:0]      ofs;
   logic            in_page;
   logic            hit_led, hit_sw, hit_seg;
   logic            read_ok, write_ok, err_set;
   logic [SW_W-1:0] sw_stable;
   logic            sw_pulse;
   logic [31:0]     seg_val;
   logic [31:0]     io_rdata;
   logic [23:0]     led_q, led_d;
   logic            io_err_q, io_err_d;

   assign in_page = (addr_in[31:10] == IO_BASE[31:10]);
   assign ofs     = addr_in[9:0];
   assign hit_led = in_page && (ofs == LED_OFS);
   assign hit_sw  = in_page && (ofs == SW_OFS);

`ifdef IO_BRIDGE_SEG_EN
   logic [31:0] seg_q, seg_d;

   assign hit_seg = in_page && (ofs == SEG_OFS);

   always_comb begin
      seg_d = seg_q;
      if (ioWrite && hit_seg) seg_d = r_rdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) seg_q <= '0;
      else       seg_q <= seg_d;
   end

   assign seg_val = seg_q;
`else
   assign hit_seg = 1'b0;
   assign seg_val = '0;
`endif

   assign read_ok  = hit_led | hit_sw | hit_seg;
   assign write_ok = hit_led | hit_seg;

   // Switch offset is read-only, so a write there counts as an unmapped access.
   assign err_set = (ioRead  && !read_ok)
                  | (ioWrite && !write_ok)
                  | multi_strobe({mRead, mWrite, ioRead, ioWrite});

   sw_debounce #(
      .WIDTH          (SW_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sw_debounce (
      .clock    (clock),
      .reset    (reset),
      .raw_i    (switch_in),
      .stable_o (sw_stable),
      .changed_o(sw_pulse)
   );

   always_comb begin
      io_rdata = '0;
      if (hit_led)     io_rdata = {8'h00, led_q};
      else if (hit_sw) io_rdata = {8'h00, sw_stable};
      else if (hit_seg) io_rdata = seg_val;
   end

   always_comb begin
      r_wdata = '0;
      if (mRead)       r_wdata = m_rdata;
      else if (ioRead) r_wdata = io_rdata;
   end

   always_comb begin
      led_d = led_q;
      if (ioWrite && hit_led) led_d = r_rdata[23:0];
      io_err_d = io_err_q | err_set;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         led_q    <= '0;
         io_err_q <= 1'b0;
      end else begin
         led_q    <= led_d;
         io_err_q <= io_err_d;
      end
   end

   assign write_data = r_rdata;
   assign led_out    = led_q;
   assign seg_out    = seg_val;
   assign sw_changed = sw_pulse;
   assign io_err     = io_err_q;

endmodule
